// File: rtl/s_machine_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, FSM states,
// instruction field positions and per-opcode operand/writeback helpers.
package s_machine_pkg;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int MASK_HI = 10;
  localparam int MASK_LO = 8;
  localparam int IDX_A_LO = 0;
  localparam int IDX_B_LO = 3;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_EXCH = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SET  = 4'b1101;
  localparam logic [3:0] OP_CLR  = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_WAIT, S_EXEC, S_WB_A, S_WB_B, S_DONE
  } state_e;

  function automatic logic needs_b(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_EXCH) || (op == OP_CMP);
  endfunction

  function automatic logic writes_a(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_SHR) || (op == OP_EXCH);
  endfunction

  function automatic logic writes_b(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_EXCH);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: reads operands from the RF, drives the ALU, writes back.
// Accepts one instruction only in IDLE (ADD done at T+6, EXCH T+7); inst_valid elsewhere is ignored.
module alu_sequencer
  import s_machine_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [15:0]       inst,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [15:0]       alu_inst,
  output logic [DATA_W-1:0] alu_a_in,
  output logic [DATA_W-1:0] alu_b_in,
  output logic              alu_z_in,
  output logic              alu_n_in,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_a_out,
  input  logic [DATA_W-1:0] alu_b_out,
  input  logic              alu_z_out,
  input  logic              alu_n_out,
  input  logic              alu_c_out,
  output logic              psw_z,
  output logic              psw_n,
  output logic              psw_c,
  output logic              done,
  output logic              illegal
);

  state_e              state_q, state_d;
  logic [15:0]         inst_q, inst_d;
  logic                ill_q, ill_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0]   resa_q, resa_d, resb_q, resb_d;
  logic                z_q, z_d, n_q, n_d, c_q, c_d;

  logic [3:0]          op_q, op_in;
  logic [ADDR_W-1:0]   idx_a, idx_b;

  assign op_q  = inst_q[OPC_HI:OPC_LO];
  assign op_in = inst[OPC_HI:OPC_LO];
  assign idx_a = inst_q[IDX_A_LO +: ADDR_W];
  assign idx_b = inst_q[IDX_B_LO +: ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      ill_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      resa_q  <= '0;
      resb_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ill_q   <= ill_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      resa_q  <= resa_d;
      resb_q  <= resb_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    ill_d      = ill_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    resa_d     = resa_q;
    resb_d     = resb_q;
    z_d        = z_q;
    n_d        = n_q;
    c_d        = c_q;
    inst_ready = 1'b0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    alu_inst   = 16'h0000;
    done       = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          inst_d = inst;
          ill_d  = 1'b0;
          if (op_in == OP_SET || op_in == OP_CLR) begin
            state_d = S_EXEC;
          end else if (op_in >= OP_ADD && op_in <= OP_CMP) begin
            state_d = S_RD_A;
          end else begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RD_A: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = idx_a;
        state_d    = needs_b(op_q) ? S_RD_B : S_WAIT;
      end
      S_RD_B: begin
        opa_d      = rf_rd_data;
        rf_rd_en   = 1'b1;
        rf_rd_addr = idx_b;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (needs_b(op_q)) opb_d = rf_rd_data;
        else               opa_d = rf_rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The ALU only evaluates on an edge of its instruction input.
        alu_inst = inst_q;
        resa_d   = alu_a_out;
        resb_d   = alu_b_out;
        z_d      = alu_z_out;
        n_d      = alu_n_out;
        c_d      = alu_c_out;
        if (writes_a(op_q))      state_d = S_WB_A;
        else if (writes_b(op_q)) state_d = S_WB_B;
        else                     state_d = S_DONE;
      end
      S_WB_A: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = idx_a;
        rf_wr_data = resa_q;
        state_d    = writes_b(op_q) ? S_WB_B : S_DONE;
      end
      S_WB_B: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = idx_b;
        rf_wr_data = resb_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = ill_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset kills side effects in the very cycle it is asserted.
    if (rst) begin
      inst_ready = 1'b0;
      rf_rd_en   = 1'b0;
      rf_wr_en   = 1'b0;
      alu_inst   = 16'h0000;
      done       = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign alu_a_in = opa_q;
  assign alu_b_in = opb_q;
  assign alu_z_in = z_q;
  assign alu_n_in = n_q;
  assign alu_c_in = c_q;
  assign psw_z    = z_q;
  assign psw_n    = n_q;
  assign psw_c    = c_q;

endmodule
